// File: rtl/program_counter_fetch_pkg.sv
// -----------------------------------------------------------------------------
// program_counter_fetch_pkg
// Shared types and constants for the program counter / fetch stage.
//   PcStates       : fetch controller state encoding (BOOT, RUN, FAULT).
//   PC_ALIGN_MASK  : low address bits that must be zero for a legal fetch PC.
//   is_misaligned  : true when an address has any PC_ALIGN_MASK bit set.
// -----------------------------------------------------------------------------
package program_counter_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'h0,
    RUN   = 2'h1,
    FAULT = 2'h2
  } PcStates;

  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & PC_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/program_counter_fetch_if.sv
// -----------------------------------------------------------------------------
// program_counter_fetch_if
// Valid/ready fetch request bus between the PC stage and instruction memory.
//   fetchValid   : request outstanding (driven by the PC stage).
//   fetchAddress : word-aligned request address (driven by the PC stage).
//   fetchReady   : memory accepts the request this cycle.
// master = PC stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface program_counter_fetch_if;

  logic        fetchValid;
  logic        fetchReady;
  logic [31:0] fetchAddress;

  modport master (output fetchValid, output fetchAddress, input fetchReady);
  modport slave  (input fetchValid, input fetchAddress, output fetchReady);

endinterface

// File: rtl/pc_redirect_buffer.sv
// -----------------------------------------------------------------------------
// pc_redirect_buffer
// One-entry holding register for a redirect that arrived while no fetch
// handshake could complete. A newer capture overwrites an older entry.
//   clk, rst           : clock, asynchronous active-low reset.
//   capture_i          : load target_i and mark the entry valid.
//   target_i           : redirect base from the branch unit.
//   consume_i          : a completed fetch used (or superseded) the entry.
//   flush_i            : discard the entry (misalignment trap).
//   pending_valid_o    : entry holds a redirect not yet applied.
//   pending_target_o   : stored redirect base.
// Priority: flush > capture > consume.
// -----------------------------------------------------------------------------
module pc_redirect_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  logic [31:0] target_i,
  input  logic        consume_i,
  input  logic        flush_i,
  output logic        pending_valid_o,
  output logic [31:0] pending_target_o
);

  logic        pending_valid_q;
  logic [31:0] pending_target_q;

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_valid_q  <= 1'b0;
      // NOTE: the target is a single register, not a memory array, so it is
      // reset too; this keeps the stored value deterministic after reset.
      pending_target_q <= 32'h0;
    end else if (flush_i) begin
      pending_valid_q  <= 1'b0;
    end else if (capture_i) begin
      pending_valid_q  <= 1'b1;
      pending_target_q <= target_i;
    end else if (consume_i) begin
      pending_valid_q  <= 1'b0;
    end
  end

  assign pending_valid_o  = pending_valid_q;
  assign pending_target_o = pending_target_q;

endmodule

// File: rtl/program_counter_fetch.sv
// -----------------------------------------------------------------------------
// program_counter_fetch
// Owns the architectural PC and issues fetch requests over a valid/ready bus.
//   clk, rst        : clock, asynchronous active-low reset.
//   shouldUseNewPC  : redirect request from the branch unit.
//   branchTo        : redirect base (the branch unit pre-subtracts one step).
//   stall           : blocks issue of a new request (not an outstanding one).
//   fetch           : fetch bus master (fetchValid/fetchAddress/fetchReady).
//   pcAddress       : current PC, also the address of any outstanding request.
//   fault           : sticky misaligned-redirect trap.
//   faultAddress    : the misaligned target that caused the trap.
//   fetchCount      : completed handshakes, wrapping.
// -----------------------------------------------------------------------------
module program_counter_fetch
  import program_counter_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shouldUseNewPC,
  input  logic [31:0]                   branchTo,
  input  logic                          stall,
  program_counter_fetch_if.master       fetch,
  output logic [31:0]                   pcAddress,
  output logic                          fault,
  output logic [31:0]                   faultAddress,
  output logic [31:0]                   fetchCount
);

  PcStates     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] count_q, count_d;

  logic        pending_valid;
  logic [31:0] pending_target;
  logic        buf_capture, buf_consume, buf_flush;

  logic        completion;
  logic        redirect_sel;
  logic [31:0] next_base;
  logic [31:0] next_pc;

  pc_redirect_buffer u_redirect_buffer (
    .clk              (clk),
    .rst              (rst),
    .capture_i        (buf_capture),
    .target_i         (branchTo),
    .consume_i        (buf_consume),
    .flush_i          (buf_flush),
    .pending_valid_o  (pending_valid),
    .pending_target_o (pending_target)
  );

  // A live redirect outranks a buffered one, which outranks sequential flow.
  // Redirect bases already have one step subtracted, so every path adds it.
  assign completion   = (state_q == RUN) && valid_q && fetch.fetchReady;
  assign redirect_sel = shouldUseNewPC || pending_valid;
  assign next_base    = shouldUseNewPC ? branchTo
                      : pending_valid  ? pending_target
                      :                  pc_q;
  assign next_pc      = next_base + PC_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      count_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    buf_capture  = 1'b0;
    buf_consume  = 1'b0;
    buf_flush    = 1'b0;

    unique case (state_q)
      BOOT: begin
        buf_capture = shouldUseNewPC;
        if (!stall) begin
          state_d = RUN;
          valid_d = 1'b1;
        end
      end

      RUN: begin
        if (completion) begin
          // The request being accepted is delivered even if it traps.
          count_d = count_q + 32'd1;
          if (redirect_sel && is_misaligned(next_pc)) begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_addr_d = next_pc;
            valid_d      = 1'b0;
            buf_flush    = 1'b1;
          end else begin
            pc_d        = next_pc;
            valid_d     = !stall;
            // Clears a buffered redirect whether it was used or superseded.
            buf_consume = 1'b1;
          end
        end else begin
          // Outstanding-but-unaccepted requests hold; stall only gates issue.
          buf_capture = shouldUseNewPC;
          if (!valid_q && !stall) begin
            valid_d = 1'b1;
          end
        end
      end

      FAULT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = FAULT;
        valid_d = 1'b0;
      end
    endcase
  end

  assign fetch.fetchValid   = valid_q;
  assign fetch.fetchAddress = pc_q;
  assign pcAddress          = pc_q;
  assign fault              = fault_q;
  assign faultAddress       = fault_addr_q;
  assign fetchCount         = count_q;

endmodule

// File: doc/program_counter_fetch.md
Name: program_counter_fetch

Overview:
Program counter stage directly downstream of the branch unit. Consumes the branch unit's shouldUseNewPC/branchTo pair and owns the architectural PC. Issues word-aligned fetch requests to instruction memory over a valid/ready handshake. Redirects that arrive while a request is stalled are buffered, and misaligned redirect targets are trapped.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; first fetch address.
PC_STEP, 32'd4, byte increment per sequential instruction.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
shouldUseNewPC  input  1  redirect request from branch unit; sampled every cycle.
branchTo  input  32  redirect base from branch unit; valid only when shouldUseNewPC=1.
stall  input  1  pipeline hold; blocks issue of a new request.
fetchReady  input  1  instruction memory accepts fetchAddress this cycle.
fetchValid  output  1  request outstanding (registered).
fetchAddress  output  32  address of outstanding request; always equals pcAddress.
pcAddress  output  32  current PC (registered); fed back to branch unit.
fault  output  1  sticky misaligned-target trap.
faultAddress  output  32  offending target address.
fetchCount  output  32  completed handshakes; wraps modulo 2^32.

Behaviour:
- Reset (rst=0, asynchronous) sets: pcAddress=RESET_VECTOR, fetchValid=0, fault=0, faultAddress=0, fetchCount=0, pending buffer empty, state=BOOT.
- States:
  - BOOT: always goes to RUN on the next clock with fetchValid=1, unless stall=1, which holds BOOT.
  - RUN: normal operation.
  - FAULT: terminal; only rst exits.
- Handshake completes in a cycle where fetchValid=1 and fetchReady=1.
- While fetchValid=1 and fetchReady=0, fetchValid and fetchAddress hold stable. stall is ignored until completion.
- On completion, pcAddress <= nextPc and fetchCount increments.
  - fetchValid next = !stall. Latency: the next request is visible the cycle after completion.
- If fetchValid=0 in RUN and stall=0, fetchValid goes to 1 on the next clock with the current pcAddress.
- nextPc selection, priority high to low:
  1. Live redirect (shouldUseNewPC=1): branchTo + PC_STEP.
  2. Pending buffer valid: pendingTarget + PC_STEP.
  3. Otherwise: pcAddress + PC_STEP.
  - The +PC_STEP on redirects is mandatory. The branch unit pre-subtracts 4 from jump targets, and branch targets assume the post-increment.
- Redirect with no completion that cycle: latch branchTo into pendingTarget and set pendingValid.
  - A newer redirect overwrites an older pending one; newest wins.
  - pendingValid clears on the completion that consumes it, or when a live redirect supersedes it at completion.
- Arithmetic: all 32-bit unsigned, wrapping. 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no fault.
- Misalignment check applies only to the selected redirect-based nextPc, at completion, when nextPc[1:0] != 0. The completing request itself is delivered. On the clock:
  - state=FAULT, fault=1, faultAddress=nextPc, fetchValid=0.
  - pcAddress is unchanged and the pending buffer is cleared.
  - fetchCount still increments for that completion.
- In FAULT: fetchValid stays 0, and all inputs are ignored.
- Reset mid-request drops the request immediately. fetchValid goes to 0 asynchronously with no handshake owed.
- In BOOT, a redirect is latched into the pending buffer.

Decomposition:
- Shared package PcStatesPackage:
  - typedef enum logic [1:0] PcStates {BOOT=2'h0, RUN=2'h1, FAULT=2'h2}.
  - localparam PC_ALIGN_MASK = 2'b11.
- One natural sub-module, pc_redirect_buffer:
  - Holds pendingValid/pendingTarget.
  - Inputs: capture, consume, flush.
  - Resets asynchronously with rst.
- Top level holds the state machine, nextPc mux, alignment check and counter.

Test Plan:
1. Reset, stall=0, fetchReady=1 constantly: cycle1 fetchAddress=0x0, then 0x4, 0x8, 0xC on successive cycles. fetchCount=4 after the 4th completion.
2. Redirect during completion: pc=0x100, shouldUseNewPC=1, branchTo=0x1FC, fetchReady=1 -> next fetchAddress=0x200.
3. Redirect during backpressure: pc=0x40, fetchReady=0 for 3 cycles, shouldUseNewPC=1 with branchTo=0x7C in cycle 1 and then 0x8C in cycle 2.
   - fetchAddress holds 0x40 throughout.
   - After fetchReady=1, fetchAddress=0x90 (newest wins).
4. Stall: stall=1 asserted while fetchValid=1, fetchReady=0 -> fetchValid stays 1 until accepted, then 0 while stall=1. It reissues pc+4 one cycle after stall drops.
5. Misaligned redirect: branchTo=0x1001, completion -> fault=1, faultAddress=0x1005, fetchValid=0.
   - It stays in FAULT for 10 cycles despite further redirects.
   - rst pulse restores pcAddress=RESET_VECTOR and fault=0.
6. Wrap: pc=0xFFFF_FFFC, fetchReady=1 -> next fetchAddress=0x0000_0000, fault=0.
